// File: rtl/pulse2lvl.sv
// Purpose : stretch each single-cycle event pulse into one HOLD_CYCLES-long level window
//           followed by a GAP_CYCLES low gap; pulses arriving mid-window are queued.
// Latency : pulse sampled at edge t -> lvl high from cycle t+1; no input can stall the block.
// Backpressure: none upstream; up to MAX_PENDING events queue while busy, further events drop.
//
// Ports:
//   clk      in   single clock, posedge
//   rst      in   synchronous active-high reset
//   pulse    in   event input, each high cycle is one event
//   lvl      out  stretched level (registered)
//   busy     out  high while a window or its trailing gap is in progress (registered)
//   pending  out  number of queued events (registered)
//   ovf_clr  in   clears ovf            (only with PULSE2LVL_OVF_EN defined)
//   ovf      out  sticky event-drop flag (only with PULSE2LVL_OVF_EN defined)
//
// Build option: define PULSE2LVL_OVF_EN to add the ovf/ovf_clr drop-flag logic.

module pulse2lvl #(
    parameter int  HOLD_CYCLES = 4,
    parameter int  GAP_CYCLES  = 2,
    parameter int  MAX_PENDING = 3,
    localparam int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse,
`ifdef PULSE2LVL_OVF_EN
    input  logic          ovf_clr,
    output logic          ovf,
`endif
    output logic          lvl,
    output logic          busy,
    output logic [PW-1:0] pending
);

    // One down-counter serves both HIGH and GAP, so size it for the longer phase.
    localparam int            CMAX      = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int            CW        = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW-1:0] pending_nxt;
    logic          last_gap;
    logic          inc;
    logic          dec;

    assign last_gap = (state == GAP) && (cnt == '0);

    // A pulse is consumed directly (never queued) when it can start a window right away:
    // in IDLE, or on the last gap cycle with nothing already waiting ahead of it.
    assign inc = pulse && (state != IDLE) && !(last_gap && (pending == '0));
    assign dec = last_gap && (pending != '0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pending_nxt = pending;

        case (state)
            IDLE: begin
                if (pulse) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                end
            end
            HIGH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if ((pending != '0) || pulse) begin
                    state_nxt = HIGH;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // inc together with dec leaves the count unchanged, even at saturation:
        // the new event simply takes the slot freed by the one being launched.
        if (inc && !dec) begin
            if (pending != PEND_MAX) begin
                pending_nxt = pending + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pending_nxt = pending - PEND_ONE;
        end
    end

    // Outputs are registered from the next-state so lvl/busy line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            lvl     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            lvl     <= (state_nxt == HIGH);
            busy    <= (state_nxt != IDLE);
        end
    end

`ifdef PULSE2LVL_OVF_EN
    logic drop;

    assign drop = inc && !dec && (pending == PEND_MAX);

    // Set has priority over clear so a drop coinciding with ovf_clr is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pulse2lvl.sv
module tb_pulse2lvl;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int P    = H + G;
    localparam int MAXP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       lvl;
    logic       busy;
    logic [1:0] pending;
`ifdef PULSE2LVL_OVF_EN
    logic       ovf;
`endif

    always #5 clk = ~clk;

    pulse2lvl dut (
        .clk     (clk),
        .rst     (rst),
        .pulse   (pulse),
`ifdef PULSE2LVL_OVF_EN
        .ovf_clr (ovf_clr),
        .ovf     (ovf),
`endif
        .lvl     (lvl),
        .busy    (busy),
        .pending (pending)
    );

    typedef struct {
        int  cyc;
        bit  lvl;
        bit  busy;
        int  pend;
        bit  ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   max_pend_seen = 0;

    // Reference model: each window is described only by its start cycle ws.
    // A window occupies [ws, ws+P); lvl is high over [ws, ws+H).
    int   ws = -1000;
    int   qn = 0;
    bit   ovf_m = 1'b0;
    int   t = 0;

    task automatic step(input bit p, input bit r, input bit c);
        exp_t e;
        bit   drop;
        @(negedge clk);
        pulse   = p;
        rst     = r;
        ovf_clr = c;
        drop    = 1'b0;
        if (r) begin
            ws    = -1000;
            qn    = 0;
            ovf_m = 1'b0;
        end else begin
            if (!(t >= ws && t < ws + P)) begin
                if (p) ws = t + 1;
            end else if (t == ws + P - 1) begin
                if (qn > 0) begin
                    ws = t + 1;
                    if (!p) qn = qn - 1;
                end else if (p) begin
                    ws = t + 1;
                end
            end else if (p) begin
                if (qn < MAXP) qn = qn + 1;
                else drop = 1'b1;
            end
            if (drop) ovf_m = 1'b1;
            else if (c) ovf_m = 1'b0;
        end
        e.cyc  = t + 1;
        e.lvl  = (t + 1 >= ws) && (t + 1 < ws + H);
        e.busy = (t + 1 >= ws) && (t + 1 < ws + P);
        e.pend = qn;
        e.ovf  = ovf_m;
        exp_q.push_back(e);
        t = t + 1;
    endtask

    task automatic run_pattern(input logic [31:0] pat, input int len);
        logic [31:0] pv;
        pv = pat;
        for (int i = 0; i < len; i++) step(pv[i], 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set; pop and compare.
    initial begin
        exp_t e;
        bit   ok;
        bit   ovf_act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ovf_act = e.ovf;
`ifdef PULSE2LVL_OVF_EN
                ovf_act = ovf;
`endif
                ok = (lvl === e.lvl) && (busy === e.busy) &&
                     (int'(pending) == e.pend) && (ovf_act == e.ovf) && !$isunknown(pending);
                total++;
                if (int'(pending) > max_pend_seen) max_pend_seen = int'(pending);
                if (!ok) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got lvl=%0b busy=%0b pending=%0d ovf=%0b need lvl=%0b busy=%0b pending=%0d ovf=%0b",
                             e.cyc, lvl, busy, pending, ovf_act, e.lvl, e.busy, e.pend, e.ovf);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        // reset state
        repeat (3) step(1'b1, 1'b1, 1'b0);
        run_pattern(32'h0, 10);
        // single event
        run_pattern(32'h0000_0001, 14);
        // three back-to-back events
        run_pattern(32'h0000_0007, 26);
        // five events: saturation and one drop, then clear the flag
        run_pattern(32'h0000_001F, 28);
        step(1'b0, 1'b0, 1'b1);
        run_pattern(32'h0, 4);
        // event on the last gap cycle with nothing queued
        run_pattern(32'h0000_0041, 16);
        // reset mid-operation together with a pulse
        run_pattern(32'h0000_0007, 3);
        step(1'b1, 1'b1, 1'b0);
        run_pattern(32'h0, 16);
        // drop and clear on the same cycle: set must win
        run_pattern(32'h0000_000F, 4);
        step(1'b1, 1'b0, 1'b1);
        run_pattern(32'h0, 30);
        // randomized traffic with varying density
        for (int blk = 0; blk < 20; blk++) begin
            int dens;
            dens = $urandom_range(1, 8);
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 9) < dens),
                     ($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 19) == 0));
            end
        end
        step(1'b0, 1'b0, 1'b0);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain remaining=%0d need 0", exp_q.size());
        end
        total++;
        if (max_pend_seen != MAXP) begin
            bad++;
            $display("FAIL max_pending got %0d need %0d", max_pend_seen, MAXP);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
